redirect_ctrl: RTL and testbench
================================

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, address width.
REQ-002 SHALL have parameter RST_PC, default 64'h80000000, value driven on redir_addr while idle after reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 trap_req / trap_addr  in  1 / XLEN  trap or exception redirect from commit.
REQ-006 jalr_req / jalr_addr  in  1 / XLEN  resolved JALR target from EX.
REQ-007 br_miss / br_addr  in  1 / XLEN  branch mispredict correction from EX.
REQ-008 jal_req / jal_addr  in  1 / XLEN  JAL target from ID.
REQ-009 pr_req / pr_addr  in  1 / XLEN  predicted-taken target from IF.
REQ-010 pipe_stall  in  1  hazard-unit stall of front end.
REQ-011 fetch_rdy  in  1  fetch unit can accept a new PC this cycle.
REQ-012 redir_valid / redir_addr / redir_src  out  1 / XLEN / 3  redirect issued to PC register; src one of NONE, TRAP, JALR, BR, JAL, PR.
REQ-013 flush_if / flush_id / flush_ex  out  1 each  squash stage contents this cycle.
REQ-014 fetch_hold  out  1  freeze sequential PC increment.
REQ-015 redir_cnt  out  32  count of issued redirects.

Function
REQ-016 Priority SHALL be TRAP > JALR > BR > JAL > PR; only the winner is acted on per cycle.
REQ-017 TRAP, JALR, BR SHALL be eligible regardless of pipe_stall; JAL and PR SHALL be eligible only when pipe_stall=0.
REQ-018 States SHALL be IDLE and PEND.
REQ-019 IDLE, winner present, fetch_rdy=1: redir_valid=1, redir_addr/src = winner, same cycle (combinational); stay IDLE.
REQ-020 IDLE, winner present, fetch_rdy=0: latch winner addr/src into pending register at clock edge, go PEND; redir_valid=0.
REQ-021 PEND: fetch_hold=1; redir_valid=0 while fetch_rdy=0.
REQ-022 PEND, fetch_rdy=1: issue the pending entry, or the new winner if it outranks or equals the pending source; go IDLE.
REQ-023 PEND, fetch_rdy=0, new winner of higher or equal priority: overwrite pending register; lower priority requests SHALL be dropped.
REQ-024 Flushes SHALL assert in the cycle a request is accepted (issued or latched), not when issued from PEND: TRAP -> IF,ID,EX; JALR, BR -> IF,ID; JAL -> IF; PR -> none.
REQ-025 redir_cnt SHALL increment by 1 per cycle redir_valid=1, wrapping at 2^32-1 to 0.
REQ-026 No request and IDLE: all flush, redir_valid, fetch_hold = 0; redir_src=NONE.

Reset
REQ-027 On rst_n=0, asynchronously: state IDLE, pending register cleared (src NONE, addr RST_PC), redir_cnt=0.
REQ-028 Reset during PEND SHALL discard the pending redirect; no redirect is issued after reset release.
REQ-029 All outputs SHALL be 0 during reset except redir_addr=RST_PC.

Structure
REQ-030 State enum, redir_src encoding and RST_PC default SHALL live in shared package rv6_redir_pkg.
REQ-031 Priority selection SHALL be a sub-module redir_prio_enc (requests + pipe_stall in, one-hot winner, src, addr out); the FSM, pending register and counter stay in redirect_ctrl.

Verification
REQ-032 br_miss=1, br_addr=0x80000100, jal_req=1, fetch_rdy=1 -> same cycle redir_valid=1, addr 0x80000100, src BR, flush_if=flush_id=1, flush_ex=0.
REQ-033 jal_req=1, pipe_stall=1, no other request -> redir_valid=0, no flush, state IDLE.
REQ-034 fetch_rdy=0, jalr_req 0x80000200 cycle 0, br_miss 0x80000300 cycle 1, fetch_rdy=1 cycle 3 -> fetch_hold cycles 1-3, BR dropped, cycle 3 redir_valid=1 addr 0x80000200 src JALR.
REQ-035 PEND holding PR 0x80000040, trap_req 0x80000004 with fetch_rdy=0 -> flush_if/id/ex=1 that cycle, pending overwritten; on fetch_rdy=1 issue 0x80000004 src TRAP.
REQ-036 Enter PEND, assert rst_n=0 mid-PEND, release -> redir_valid stays 0, redir_cnt=0, redir_addr=0x80000000.
REQ-037 Preload redir_cnt near 0xFFFFFFFF via 2^32-1 issued redirects (or force) -> next issue wraps redir_cnt to 0.

Source files
------------

// File: rtl/rv6_redir_pkg.sv
// Shared types for the front-end redirect controller: source encoding, FSM states,
// reset PC and the per-source flush mask.
package rv6_redir_pkg;

   localparam logic [63:0] RST_PC_DEFAULT = 64'h0000_0000_8000_0000;

   // Numerically lower non-NONE code means higher priority.
   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_TRAP = 3'd1,
      SRC_JALR = 3'd2,
      SRC_BR   = 3'd3,
      SRC_JAL  = 3'd4,
      SRC_PR   = 3'd5
   } redir_src_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } redir_state_e;

   // Returns {flush_ex, flush_id, flush_if} for a redirect from src.
   function automatic logic [2:0] flush_mask(input redir_src_e src);
      logic [2:0] m;
      m = 3'b000;
      case (src)
         SRC_TRAP:        m = 3'b111;
         SRC_JALR, SRC_BR: m = 3'b011;
         SRC_JAL:         m = 3'b001;
         default:         m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic outranks_eq(input redir_src_e a, input redir_src_e b);
      return (a != SRC_NONE) && ((b == SRC_NONE) || (a <= b));
   endfunction

endpackage

// File: rtl/redir_prio_enc.sv
// Fixed-priority pick among the five redirect requests. JAL and PR come from
// stages the hazard unit can stall, so they are masked while pipe_stall is high.
module redir_prio_enc
   import rv6_redir_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            jalr_req,
   input  logic [XLEN-1:0] jalr_addr,
   input  logic            br_miss,
   input  logic [XLEN-1:0] br_addr,
   input  logic            jal_req,
   input  logic [XLEN-1:0] jal_addr,
   input  logic            pr_req,
   input  logic [XLEN-1:0] pr_addr,
   input  logic            pipe_stall,
   output logic [4:0]      win_oh,
   output redir_src_e      win_src,
   output logic [XLEN-1:0] win_addr
);

   always_comb begin
      win_oh   = 5'b00000;
      win_src  = SRC_NONE;
      win_addr = '0;
      if (trap_req) begin
         win_oh   = 5'b00001;
         win_src  = SRC_TRAP;
         win_addr = trap_addr;
      end else if (jalr_req) begin
         win_oh   = 5'b00010;
         win_src  = SRC_JALR;
         win_addr = jalr_addr;
      end else if (br_miss) begin
         win_oh   = 5'b00100;
         win_src  = SRC_BR;
         win_addr = br_addr;
      end else if (jal_req && !pipe_stall) begin
         win_oh   = 5'b01000;
         win_src  = SRC_JAL;
         win_addr = jal_addr;
      end else if (pr_req && !pipe_stall) begin
         win_oh   = 5'b10000;
         win_src  = SRC_PR;
         win_addr = pr_addr;
      end
   end

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect controller: picks the winning redirect, issues it to the PC
// register when fetch is ready, otherwise parks it in a one-entry pending register.
module redirect_ctrl
   import rv6_redir_pkg::*;
#(
   parameter int              XLEN   = 64,
   parameter logic [XLEN-1:0] RST_PC = XLEN'(RST_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            jalr_req,
   input  logic [XLEN-1:0] jalr_addr,
   input  logic            br_miss,
   input  logic [XLEN-1:0] br_addr,
   input  logic            jal_req,
   input  logic [XLEN-1:0] jal_addr,
   input  logic            pr_req,
   input  logic [XLEN-1:0] pr_addr,
   input  logic            pipe_stall,
   input  logic            fetch_rdy,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_addr,
   output logic [2:0]      redir_src,
   output logic            flush_if,
   output logic            flush_id,
   output logic            flush_ex,
   output logic            fetch_hold,
   output logic [31:0]     redir_cnt,
   output logic            dbg_state
);

   // Handshake: a redirect transfers in any cycle where redir_valid is high; the
   // controller only raises redir_valid when fetch_rdy is high in that same cycle.

   redir_state_e    state_q, state_d;
   redir_src_e      pend_src_q, pend_src_d;
   logic [XLEN-1:0] pend_addr_q, pend_addr_d;
   logic [31:0]     cnt_q, cnt_d;

   logic [4:0]      win_oh;
   redir_src_e      win_src;
   logic [XLEN-1:0] win_addr;
   logic            win_vld;
   logic            take_win;
   logic            issue;
   redir_src_e      issue_src;
   logic [XLEN-1:0] issue_addr;
   logic [2:0]      flush_vec;

   redir_prio_enc #(.XLEN(XLEN)) u_prio (
      .trap_req   (trap_req),
      .trap_addr  (trap_addr),
      .jalr_req   (jalr_req),
      .jalr_addr  (jalr_addr),
      .br_miss    (br_miss),
      .br_addr    (br_addr),
      .jal_req    (jal_req),
      .jal_addr   (jal_addr),
      .pr_req     (pr_req),
      .pr_addr    (pr_addr),
      .pipe_stall (pipe_stall),
      .win_oh     (win_oh),
      .win_src    (win_src),
      .win_addr   (win_addr)
   );

   // Requests are ignored while reset is held so every output stays quiet.
   assign win_vld = rst_n && (win_oh != 5'b00000);

   always_comb begin
      state_d     = state_q;
      pend_src_d  = pend_src_q;
      pend_addr_d = pend_addr_q;
      take_win    = 1'b0;
      issue       = 1'b0;
      issue_src   = SRC_NONE;
      issue_addr  = pend_addr_q;
      fetch_hold  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               take_win = 1'b1;
               if (fetch_rdy) begin
                  issue      = 1'b1;
                  issue_src  = win_src;
                  issue_addr = win_addr;
               end else begin
                  state_d     = ST_PEND;
                  pend_src_d  = win_src;
                  pend_addr_d = win_addr;
               end
            end
         end
         ST_PEND: begin
            fetch_hold = 1'b1;
            take_win   = win_vld && outranks_eq(win_src, pend_src_q);
            if (fetch_rdy) begin
               issue       = 1'b1;
               issue_src   = take_win ? win_src : pend_src_q;
               issue_addr  = take_win ? win_addr : pend_addr_q;
               state_d     = ST_IDLE;
               pend_src_d  = SRC_NONE;
               pend_addr_d = RST_PC;
            end else if (take_win) begin
               pend_src_d  = win_src;
               pend_addr_d = win_addr;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Flushes follow acceptance, so a drain of an already-latched entry flushes nothing.
   assign flush_vec   = take_win ? flush_mask(win_src) : 3'b000;
   assign flush_if    = flush_vec[0];
   assign flush_id    = flush_vec[1];
   assign flush_ex    = flush_vec[2];
   assign redir_valid = issue;
   assign redir_src   = issue ? issue_src : SRC_NONE;
   assign redir_addr  = issue ? issue_addr : pend_addr_q;
   assign redir_cnt   = cnt_q;
   assign dbg_state   = state_q;
   assign cnt_d       = cnt_q + {31'd0, issue};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pend_src_q  <= SRC_NONE;
         pend_addr_q <= RST_PC;
         cnt_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         pend_src_q  <= pend_src_d;
         pend_addr_q <= pend_addr_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Randomized + directed bench for redirect_ctrl with a queue-based scoreboard and
// a behavioural model of the redirect priority/pending rules.
module tb_redirect_ctrl;

   localparam int XLEN = 64;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam int S_NONE = 0, S_TRAP = 1, S_JALR = 2, S_BR = 3, S_JAL = 4, S_PR = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            trap_req = 0, jalr_req = 0, br_miss = 0, jal_req = 0, pr_req = 0;
   logic [XLEN-1:0] trap_addr = 0, jalr_addr = 0, br_addr = 0, jal_addr = 0, pr_addr = 0;
   logic            pipe_stall = 0, fetch_rdy = 0;
   logic            redir_valid, flush_if, flush_id, flush_ex, fetch_hold, dbg_state;
   logic [XLEN-1:0] redir_addr;
   logic [2:0]      redir_src;
   logic [31:0]     redir_cnt;

   redirect_ctrl #(.XLEN(XLEN), .RST_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .trap_req(trap_req), .trap_addr(trap_addr),
      .jalr_req(jalr_req), .jalr_addr(jalr_addr),
      .br_miss(br_miss), .br_addr(br_addr),
      .jal_req(jal_req), .jal_addr(jal_addr),
      .pr_req(pr_req), .pr_addr(pr_addr),
      .pipe_stall(pipe_stall), .fetch_rdy(fetch_rdy),
      .redir_valid(redir_valid), .redir_addr(redir_addr), .redir_src(redir_src),
      .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
      .fetch_hold(fetch_hold), .redir_cnt(redir_cnt), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- staged stimulus ----------------
   logic        s_trap, s_jalr, s_br, s_jal, s_pr, s_stall, s_rdy;
   logic [63:0] s_trap_a, s_jalr_a, s_br_a, s_jal_a, s_pr_a;

   // ---------------- reference model state ----------------
   bit          m_pend_v;
   int          m_pend_src;
   logic [63:0] m_pend_addr;
   logic [31:0] m_cnt;

   typedef struct packed {
      logic        valid;
      logic [2:0]  flush;   // {ex,id,if}
      logic        hold;
      logic        state;
      logic        idle;    // no pending entry: addr must read RST_PC when not issuing
      logic [2:0]  src;
      logic [63:0] addr;
      logic [31:0] cnt;
   } ctl_t;

   ctl_t        ctl_q[$];
   logic [66:0] exp_q[$];   // {src, addr} of each expected issued redirect

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rank(input int src);
      case (src)
         S_TRAP: return 5;
         S_JALR: return 4;
         S_BR:   return 3;
         S_JAL:  return 2;
         S_PR:   return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [2:0] fmask(input int src);
      case (src)
         S_TRAP: return 3'b111;
         S_JALR: return 3'b011;
         S_BR:   return 3'b011;
         S_JAL:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic clear_stage();
      s_trap = 0; s_jalr = 0; s_br = 0; s_jal = 0; s_pr = 0;
      s_stall = 0; s_rdy = 1;
      s_trap_a = 0; s_jalr_a = 0; s_br_a = 0; s_jal_a = 0; s_pr_a = 0;
   endtask

   // One functional cycle: apply staged inputs at negedge, predict outputs, advance model.
   task automatic cycle();
      int          wsrc;
      logic [63:0] waddr;
      bit          accept;
      ctl_t        e;
      @(negedge clk);
      rst_n = 1'b1;
      trap_req = s_trap; trap_addr = s_trap_a;
      jalr_req = s_jalr; jalr_addr = s_jalr_a;
      br_miss  = s_br;   br_addr   = s_br_a;
      jal_req  = s_jal;  jal_addr  = s_jal_a;
      pr_req   = s_pr;   pr_addr   = s_pr_a;
      pipe_stall = s_stall; fetch_rdy = s_rdy;

      wsrc = S_NONE; waddr = 0;
      if (s_trap)                 begin wsrc = S_TRAP; waddr = s_trap_a; end
      else if (s_jalr)            begin wsrc = S_JALR; waddr = s_jalr_a; end
      else if (s_br)              begin wsrc = S_BR;   waddr = s_br_a;   end
      else if (s_jal && !s_stall) begin wsrc = S_JAL;  waddr = s_jal_a;  end
      else if (s_pr && !s_stall)  begin wsrc = S_PR;   waddr = s_pr_a;   end

      e = '0;
      e.hold  = m_pend_v;
      e.state = m_pend_v;
      e.idle  = !m_pend_v;
      e.addr  = RST_PC;
      e.cnt   = m_cnt;
      accept  = (wsrc != S_NONE) && (!m_pend_v || rank(wsrc) >= rank(m_pend_src));
      if (accept) e.flush = fmask(wsrc);
      if (s_rdy) begin
         if (accept) begin
            e.valid = 1; e.src = 3'(wsrc); e.addr = waddr;
         end else if (m_pend_v) begin
            e.valid = 1; e.src = 3'(m_pend_src); e.addr = m_pend_addr;
         end
         m_pend_v = 0; m_pend_src = S_NONE;
      end else if (accept) begin
         m_pend_v = 1; m_pend_src = wsrc; m_pend_addr = waddr;
      end
      ctl_q.push_back(e);
      if (e.valid) begin
         exp_q.push_back({e.src, e.addr});
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic reset_cycle();
      ctl_t e;
      @(negedge clk);
      rst_n = 1'b0;
      trap_req = 1; jalr_req = 1; br_miss = 1; jal_req = 1; pr_req = 1;
      fetch_rdy = 1; pipe_stall = 0;
      m_pend_v = 0; m_pend_src = S_NONE; m_pend_addr = RST_PC; m_cnt = 0;
      e = '0;
      e.idle = 1; e.addr = RST_PC;
      ctl_q.push_back(e);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      ctl_t        e;
      logic [66:0] r;
      forever begin
         @(negedge clk);
         #2;
         if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            check("redir_valid", 64'(redir_valid), 64'(e.valid));
            check("flush",       64'({flush_ex, flush_id, flush_if}), 64'(e.flush));
            check("fetch_hold",  64'(fetch_hold), 64'(e.hold));
            check("state",       64'(dbg_state), 64'(e.state));
            check("redir_cnt",   64'(redir_cnt), 64'(e.cnt));
            if (!e.valid) check("redir_src_idle", 64'(redir_src), 64'(S_NONE));
            if (!e.valid && e.idle) check("redir_addr_idle", redir_addr, RST_PC);
         end
         if (redir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_redirect", 64'(redir_addr), 64'(0));
            end else begin
               r = exp_q.pop_front();
               check("redir_src",  64'(redir_src), 64'(r[66:64]));
               check("redir_addr", redir_addr, r[63:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      clear_stage();
      m_pend_v = 0; m_pend_src = S_NONE; m_pend_addr = RST_PC; m_cnt = 0;
      reset_cycle();
      reset_cycle();

      // BR outranks JAL, issued same cycle
      clear_stage(); s_br = 1; s_br_a = 64'h8000_0100; s_jal = 1; s_jal_a = 64'h8000_0aaa;
      cycle();
      // JAL under stall is not eligible
      clear_stage(); s_jal = 1; s_jal_a = 64'h8000_0bbb; s_stall = 1;
      cycle();
      // JALR pending, lower BR dropped, drained when fetch ready
      clear_stage(); s_rdy = 0; s_jalr = 1; s_jalr_a = 64'h8000_0200; cycle();
      clear_stage(); s_rdy = 0; s_br = 1; s_br_a = 64'h8000_0300;     cycle();
      clear_stage(); s_rdy = 0;                                        cycle();
      clear_stage();                                                   cycle();
      clear_stage(); cycle();
      // PR pending, TRAP overwrites it
      clear_stage(); s_rdy = 0; s_pr = 1; s_pr_a = 64'h8000_0040;     cycle();
      clear_stage(); s_rdy = 0; s_trap = 1; s_trap_a = 64'h8000_0004; cycle();
      clear_stage();                                                   cycle();
      // Equal priority overwrites, then issue pending with a lower request present
      clear_stage(); s_rdy = 0; s_br = 1; s_br_a = 64'h8000_0500;     cycle();
      clear_stage(); s_rdy = 0; s_br = 1; s_br_a = 64'h8000_0504;     cycle();
      clear_stage(); s_jal = 1; s_jal_a = 64'h8000_0600;               cycle();
      // Reset in the middle of PEND discards the entry
      clear_stage(); s_rdy = 0; s_jalr = 1; s_jalr_a = 64'h8000_0700; cycle();
      reset_cycle();
      reset_cycle();
      clear_stage(); cycle();
      clear_stage(); cycle();

      // Counter wrap: preload just below the top, then issue two redirects
      @(posedge clk);
      #1 force dut.cnt_q = 32'hFFFF_FFFE;
      #1 release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      clear_stage(); s_pr = 1; s_pr_a = 64'h8000_1000; cycle();
      clear_stage(); s_pr = 1; s_pr_a = 64'h8000_1004; cycle();
      clear_stage(); cycle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_cycle();
         end else begin
            clear_stage();
            s_trap = ($urandom_range(0, 15) == 0);
            s_jalr = ($urandom_range(0, 9) == 0);
            s_br   = ($urandom_range(0, 7) == 0);
            s_jal  = ($urandom_range(0, 5) == 0);
            s_pr   = ($urandom_range(0, 3) == 0);
            s_trap_a = {$urandom, $urandom};
            s_jalr_a = {$urandom, $urandom};
            s_br_a   = {$urandom, $urandom};
            s_jal_a  = {$urandom, $urandom};
            s_pr_a   = {$urandom, $urandom};
            s_stall  = ($urandom_range(0, 3) == 0);
            s_rdy    = ($urandom_range(0, 9) < 6);
            cycle();
         end
      end

      clear_stage();
      cycle();
      cycle();
      @(negedge clk);
      #4;
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));
      check("ctl_q_drained", 64'(ctl_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
